// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
//   Shared constants, types and helpers for the (15,7) cyclic LDPC code.
//   Used by the bit-flipping decoder and its check/count datapath.
//
//   Contents:
//     N, K, INFO_LSB  code length, info length, position of the info field
//     H_ROW0          first row of the circulant parity-check matrix
//     state_t         decoder FSM state encoding
//     h_row()         row j of H (H_ROW0 rotated left by j)
//     popcount15()    number of set bits in a 15-bit word
//     sat_add16()     16-bit saturating add, used by the statistics counters
// ---------------------------------------------------------------------------
package ldpc_pkg;

    localparam int N          = 15;
    localparam int K          = 7;
    localparam int INFO_LSB   = 8;
    localparam int CNT_W      = 3;

    // Checks cover bits {0,4,6,7}; every other row is a cyclic shift of this one.
    localparam logic [N-1:0] H_ROW0 = 15'h00D1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_FLIP  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_CHECK = S_CHECK,
        ST_FLIP  = S_FLIP,
        ST_DONE  = S_DONE
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Rotate-left by j is taken as a window into the row concatenated with itself,
    // so that bit k of the result is H_ROW0[(k - j) mod N].
    function automatic logic [N-1:0] h_row(input int j);
        logic [2*N-1:0] dbl;
        dbl = {H_ROW0, H_ROW0};
        return dbl[N-j +: N];
    endfunction

    function automatic logic [3:0] popcount15(input logic [N-1:0] v);
        logic [3:0] total;
        total = '0;
        for (int b = 0; b < N; b++) begin
            total = total + {3'd0, v[b]};
        end
        return total;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ldpc_bitflip_decoder_check_count.sv
// ---------------------------------------------------------------------------
// ldpc_check_count
//   Purely combinational syndrome and failed-check counter for one word.
//
//   Ports:
//     cword     in   15      word under test
//     syndrome  out  15      s[j] = parity of cword over row j of H
//     cnt       out  15x3    per bit, number of failing checks covering it (0..4)
// ---------------------------------------------------------------------------
module ldpc_check_count
    import ldpc_pkg::*;
(
    input  logic [N-1:0]        cword,
    output logic [N-1:0]        syndrome,
    output logic [N-1:0][CNT_W-1:0] cnt
);

    always_comb begin
        syndrome = '0;
        for (int j = 0; j < N; j++) begin
            syndrome[j] = ^(cword & h_row(j));
        end
    end

    // Each column of H has weight 4, so a bit sits in exactly four checks and
    // its count saturates naturally at 4 without overflowing three bits.
    always_comb begin
        logic [N-1:0] row;
        row = '0;
        cnt = '0;
        for (int j = 0; j < N; j++) begin
            row = h_row(j);
            for (int i = 0; i < N; i++) begin
                if (syndrome[j] && row[i]) begin
                    cnt[i] = cnt[i] + cnt_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ldpc_bitflip_decoder.sv
// ---------------------------------------------------------------------------
// ldpc_bitflip_decoder
//   Iterative bit-flipping decoder for the (15,7) cyclic LDPC code. A received
//   word is accepted over a valid/ready handshake, then the decoder alternates
//   CHECK (evaluate syndrome) and FLIP (invert every bit whose failed-check
//   count reaches FLIP_THR) until the syndrome is zero or MAX_ITER flip rounds
//   have been spent. The result is held until downstream takes it.
//
//   Parameters:
//     MAX_ITER  flip iterations allowed before declaring failure (1..15)
//     FLIP_THR  failed-check count at which a bit is flipped (1..4)
//
//   Ports:
//     clk         in   1    rising-edge clock
//     rst_n       in   1    asynchronous active-low reset
//     in_valid    in   1    channel word valid
//     in_ready    out  1    decoder idle and able to accept a word
//     c_in        in   15   received codeword
//     out_valid   out  1    result valid, held until out_ready
//     out_ready   in   1    downstream accepts the result
//     c_out       out  15   corrected codeword
//     i_out       out  7    info bits, c_out[14:8]
//     success     out  1    final syndrome was zero
//     iters       out  4    flip iterations used
//
//   Optional build macro LDPC_STATS_EN adds:
//     stat_frames out 16   completed result handshakes (saturating)
//     stat_fail   out 16   completed handshakes with success=0 (saturating)
//     stat_flips  out 16   total bits flipped across all words (saturating)
// ---------------------------------------------------------------------------
module ldpc_bitflip_decoder
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER = 4,
    parameter int FLIP_THR = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     c_out,
    output logic [K-1:0]     i_out,
    output logic             success,
    output logic [3:0]       iters
`ifdef LDPC_STATS_EN
    ,
    output logic [15:0]      stat_frames,
    output logic [15:0]      stat_fail,
    output logic [15:0]      stat_flips
`endif
);

    state_t                   state;
    logic [N-1:0]             cword;
    logic [3:0]               iter;
    logic [N-1:0]             syndrome;
    logic [N-1:0][CNT_W-1:0]  cnt;
    logic [N-1:0]             flip_mask;
    logic                     syn_zero;
    logic                     out_of_iters;

    ldpc_check_count u_check_count (
        .cword    (cword),
        .syndrome (syndrome),
        .cnt      (cnt)
    );

    // cword is only written in IDLE and FLIP, so the mask computed here during
    // FLIP reflects the same word whose syndrome was judged in the preceding CHECK.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < N; i++) begin
            flip_mask[i] = (cnt[i] >= cnt_t'(FLIP_THR));
        end
    end

    assign syn_zero     = (syndrome == '0);
    assign out_of_iters = (iter == 4'(MAX_ITER));

    // Main control FSM. All handshake and result outputs are registers that
    // change only on state transitions, so they are glitch-free and stay
    // stable throughout DONE regardless of out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cword     <= '0;
            iter      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c_out     <= '0;
            i_out     <= '0;
            success   <= 1'b0;
            iters     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        cword    <= c_in;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (syn_zero || out_of_iters) begin
                        out_valid <= 1'b1;
                        c_out     <= cword;
                        i_out     <= cword[N-1:INFO_LSB];
                        success   <= syn_zero;
                        iters     <= iter;
                        state     <= ST_DONE;
                    end else begin
                        state <= ST_FLIP;
                    end
                end

                // An empty mask still consumes an iteration, which is what
                // guarantees the loop terminates on undecodable words.
                ST_FLIP: begin
                    cword <= cword ^ flip_mask;
                    iter  <= iter + 4'd1;
                    state <= ST_CHECK;
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LDPC_STATS_EN
    // Statistics observe the FSM without feeding back into it, so enabling
    // them leaves decode timing untouched. A word aborted by reset never
    // reaches the DONE handshake and therefore is never counted as a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_fail   <= '0;
            stat_flips  <= '0;
        end else begin
            if (state == ST_DONE && out_ready) begin
                stat_frames <= sat_add16(stat_frames, 4'd1);
                if (!success) begin
                    stat_fail <= sat_add16(stat_fail, 4'd1);
                end
            end
            if (state == ST_FLIP) begin
                stat_flips <= sat_add16(stat_flips, popcount15(flip_mask));
            end
        end
    end
`endif

endmodule

// File: tb/tb_ldpc_bitflip_decoder.sv
// ---------------------------------------------------------------------------
// tb_ldpc_bitflip_decoder
//   Scoreboard bench for ldpc_bitflip_decoder. The stimulus process computes
//   each expected result with a behavioural model (codebook found by brute
//   force over all 2^15 words, decoding done with modular index arithmetic)
//   and queues it; a monitor process pops and compares whenever the DUT
//   presents a result, and also owns out_ready to apply backpressure.
// ---------------------------------------------------------------------------
module tb_ldpc_bitflip_decoder;

    localparam int MAX_ITER = 4;
    localparam int FLIP_THR = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] c_in;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] c_out;
    logic [6:0]  i_out;
    logic        success;
    logic [3:0]  iters;
`ifdef LDPC_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_fail;
    logic [15:0] stat_flips;
`endif

    ldpc_bitflip_decoder #(
        .MAX_ITER (MAX_ITER),
        .FLIP_THR (FLIP_THR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .i_out     (i_out),
        .success   (success),
        .iters     (iters)
`ifdef LDPC_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_fail   (stat_fail),
        .stat_flips  (stat_flips)
`endif
    );

    typedef struct {
        logic [14:0] c;
        logic [6:0]  info;
        logic        ok;
        int          it;
        int          lat;
        int          acceptCyc;
        int          stall;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    logic [14:0] codebook [128];
    bit          codebookOk [128];
    logic [14:0] golden;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural reference model ----------------
    // Check j covers bit i when (i - j) mod 15 is one of the row-0 taps.
    function automatic bit covers(input int j, input int i);
        int d;
        d = (i - j + 15) % 15;
        return (d == 0) || (d == 4) || (d == 6) || (d == 7);
    endfunction

    function automatic logic [14:0] modelSyndrome(input logic [14:0] c);
        logic [14:0] s;
        s = '0;
        for (int j = 0; j < 15; j++) begin
            for (int i = 0; i < 15; i++) begin
                if (covers(j, i)) s[j] = s[j] ^ c[i];
            end
        end
        return s;
    endfunction

    task automatic modelDecode(input logic [14:0] cin, output logic [14:0] cres,
                               output logic ok, output int it);
        logic [14:0] s;
        logic [14:0] nextC;
        int          count;
        bit          finished;
        cres = cin;
        ok = 1'b0;
        it = 0;
        finished = 0;
        while (!finished) begin
            s = modelSyndrome(cres);
            if (s == 15'd0) begin
                ok = 1'b1;
                finished = 1;
            end else if (it == MAX_ITER) begin
                finished = 1;
            end else begin
                nextC = cres;
                for (int i = 0; i < 15; i++) begin
                    count = 0;
                    for (int j = 0; j < 15; j++) begin
                        if (s[j] && covers(j, i)) count++;
                    end
                    if (count >= FLIP_THR) nextC[i] = ~cres[i];
                end
                cres = nextC;
                it++;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Entered and left on a falling edge. in_ready only moves on rising
    // edges, so seeing it high here guarantees acceptance at the next edge.
    task automatic applyStimulus(input logic [14:0] word, input int stall, input bit expectResult);
        exp_t e;
        int   waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        if (expectResult) begin
            modelDecode(word, e.c, e.ok, e.it);
            e.info      = e.c[14:8];
            e.lat       = 2 + 2 * e.it;
            e.acceptCyc = cyc;
            e.stall     = stall;
            expQ.push_back(e);
        end
        in_valid = 1'b1;
        c_in     = word;
        @(negedge clk);
        in_valid = 1'b0;
        c_in     = 15'($urandom);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t        cur;
        bit          active;
        int          stallLeft;
        int          idleCnt;
        logic [14:0] holdC;
        logic [6:0]  holdI;
        logic        holdS;
        logic [3:0]  holdIt;
        active    = 0;
        stallLeft = 0;
        idleCnt   = 0;
        holdC     = '0;
        holdI     = '0;
        holdS     = 1'b0;
        holdIt    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active    = 0;
                stallLeft = 0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                idleCnt = 0;
                if (!active) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
                        stallLeft = 0;
                    end else begin
                        cur = expQ.pop_front();
                        checkOutput("c_out", 32'(c_out), 32'(cur.c));
                        checkOutput("i_out", 32'(i_out), 32'(cur.info));
                        checkOutput("success", 32'(success), 32'(cur.ok));
                        checkOutput("iters", 32'(iters), 32'(cur.it));
                        checkOutput("latency", 32'(cyc - cur.acceptCyc), 32'(cur.lat));
                        checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
                        if (success)
                            checkOutput("syndrome_of_c_out", 32'(modelSyndrome(c_out)), 32'd0);
                        else
                            checkOutput("iters_on_failure", 32'(iters), 32'(MAX_ITER));
                        stallLeft = cur.stall;
                    end
                    active = 1;
                    holdC  = c_out;
                    holdI  = i_out;
                    holdS  = success;
                    holdIt = iters;
                end else begin
                    checkOutput("hold_c_out", 32'(c_out), 32'(holdC));
                    checkOutput("hold_i_out", 32'(i_out), 32'(holdI));
                    checkOutput("hold_success", 32'(success), 32'(holdS));
                    checkOutput("hold_iters", 32'(iters), 32'(holdIt));
                    checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
                end
                if (stallLeft > 0) begin
                    out_ready = 1'b0;
                    stallLeft--;
                end else begin
                    out_ready = 1'b1;
                    active = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                if (expQ.size() > 0) begin
                    idleCnt++;
                    if (idleCnt > 60) begin
                        checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
                        void'(expQ.pop_front());
                        idleCnt = 0;
                    end
                end else begin
                    idleCnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [14:0] e;
        int          w;
        int          info;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        c_in      = '0;
        out_ready = 1'b0;

        for (int v = 0; v < 128; v++) begin
            codebook[v]   = '0;
            codebookOk[v] = 0;
        end
        for (int x = 0; x < 32768; x++) begin
            logic [14:0] word;
            word = 15'(x);
            if (modelSyndrome(word) == 15'd0) begin
                codebook[word[14:8]]   = word;
                codebookOk[word[14:8]] = 1;
            end
        end
        golden = codebook[5];

        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);
        checkOutput("reset_i_out", 32'(i_out), 32'd0);
        checkOutput("reset_success", 32'(success), 32'd0);
        checkOutput("reset_iters", 32'(iters), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean word, every single-bit and every two-bit error pattern.
        applyStimulus(golden, 0, 1);
        for (int b = 0; b < 15; b++) begin
            applyStimulus(golden ^ (15'd1 << b), $urandom_range(0, 2), 1);
        end
        for (int a = 0; a < 15; a++) begin
            for (int b = a + 1; b < 15; b++) begin
                e = (15'd1 << a) | (15'd1 << b);
                applyStimulus(golden ^ e, $urandom_range(0, 1), 1);
            end
        end

        // Four-bit error: bounded run time whatever the outcome.
        applyStimulus(golden ^ 15'h0017, 0, 1);

        // Backpressure: result held five cycles while stray input is offered.
        applyStimulus(golden ^ 15'h0004, 5, 1);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            c_in     = 15'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Reset while the decoder is in FLIP (single error: CHECK then FLIP).
        applyStimulus(golden ^ 15'h0100, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_c_out", 32'(c_out), 32'd0);
        checkOutput("abort_iters", 32'(iters), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(golden ^ 15'h0200, 0, 1);
`ifdef LDPC_STATS_EN
        w = 0;
        while (expQ.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checkOutput("stat_frames_after_abort", 32'(stat_frames), 32'd1);
`endif

        // Random traffic: codewords with 0..4 random errors, plus arbitrary words.
        for (int n = 0; n < 120; n++) begin
            info = $urandom_range(0, 127);
            w = 0;
            while (!codebookOk[info] && w < 200) begin
                info = $urandom_range(0, 127);
                w++;
            end
            e = '0;
            for (int k = 0; k < $urandom_range(0, 4); k++) begin
                e[$urandom_range(0, 14)] = 1'b1;
            end
            if ($urandom_range(0, 7) == 0)
                applyStimulus(15'($urandom), $urandom_range(0, 3), 1);
            else
                applyStimulus(codebook[info] ^ e, $urandom_range(0, 3), 1);
        end

        w = 0;
        while (expQ.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (expQ.size() > 0) checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

endmodule
